fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch path.
package riscv_pkg;

    localparam logic [31:0]  NOP_INSTR           = 32'h0000_0013;
    localparam logic [63:0]  DEFAULT_RESET_PC    = 64'h0;
    localparam int unsigned  DEFAULT_FETCH_DEPTH = 2;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_e;

    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO with flush; head is read combinationally.
module fetch_fifo #(
    parameter  int unsigned WIDTH = 96,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word requests, tracks in-flight PCs, buffers
// {pc, instruction} pairs for IF/ID and discards responses after a redirect.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned FETCH_DEPTH = DEFAULT_FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall_if,
    output logic [63:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_valid
);
    localparam int unsigned CW = $clog2(FETCH_DEPTH + 1);
    localparam logic [CW:0] DEPTH_LIM = FETCH_DEPTH[CW:0];

    fetch_state_e state;
    fetch_state_e state_next;

    logic [63:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic          accept;
    logic          resp_keep;
    logic [CW:0]   in_use;

    logic [95:0]   data_head;
    logic          data_full;
    logic          data_empty;
    logic [CW-1:0] data_count;
    logic          data_pop;

    logic [63:0]   pcq_head;
    logic          pcq_full;
    logic          pcq_empty;
    logic [CW-1:0] pcq_count;
    logic          pcq_unused;

    always_ff @(posedge clk) begin
        if (!rst) state <= BOOT;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // Buffer slots are reserved at request time so a response always has room.
    assign in_use         = {1'b0, outstanding} + {1'b0, data_count};
    assign imem_req_valid = (state == RUN) && !redirect_valid && (in_use < DEPTH_LIM);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign resp_keep      = imem_resp_valid && !redirect_valid && (discard == '0);
    assign data_pop       = if_valid && !stall_if && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (redirect_valid)  fetch_pc <= align_pc(redirect_pc);
            else if (accept)     fetch_pc <= fetch_pc + 64'd4;

            case ({accept, imem_resp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (redirect_valid)
                discard <= outstanding - CW'(imem_resp_valid);
            else if (imem_resp_valid && discard != '0)
                discard <= discard - 1'b1;
        end
    end

    // In-flight PCs are flushed on redirect; the stale responses they belonged
    // to are consumed by the discard counter instead of popping this queue.
    fetch_fifo #(.WIDTH(64), .DEPTH(FETCH_DEPTH)) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (accept),
        .pop   (resp_keep),
        .din   (fetch_pc),
        .head  (pcq_head),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    fetch_fifo #(.WIDTH(96), .DEPTH(FETCH_DEPTH)) u_fetch_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (resp_keep),
        .pop   (data_pop),
        .din   ({pcq_head, imem_resp_data}),
        .head  (data_head),
        .full  (data_full),
        .empty (data_empty),
        .count (data_count)
    );

    assign pcq_unused     = ^{pcq_full, pcq_empty, pcq_count, data_full};
    assign if_valid       = !data_empty;
    assign if_pc          = if_valid ? data_head[95:32] : 64'h0;
    assign if_instruction = if_valid ? data_head[31:0]  : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised fetch_unit bench: memory model plus an expected-PC-stream scoreboard.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        stall_if = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;

    fetch_unit #(.RESET_PC(64'h0), .FETCH_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall_if        (stall_if),
        .if_pc           (if_pc),
        .if_instruction  (if_instruction),
        .if_valid        (if_valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; longint unsigned due; } mreq_t;
    typedef struct { logic [63:0] pc; logic [31:0] ins; } exp_t;

    int               checks = 0;
    int               failures = 0;
    int               popped = 0;
    longint unsigned  cyc = 0;
    mreq_t            mem_q[$];
    exp_t             exp_q[$];
    logic [63:0]      exp_next = 64'h0;
    logic [63:0]      tb_req_pc = 64'h0;
    bit               rst_req = 1'b0;
    bit               rst_prev = 1'b0;

    int unsigned      p_ready = 100, min_lat = 1, max_lat = 1, p_stall = 0, p_redir = 0;
    bit               force_stall = 0, force_redir = 0, redir_on_resp = 0;
    logic [63:0]      force_target = '0;

    function automatic logic [31:0] ins_of(input logic [63:0] pc);
        return (pc[31:0] * 32'h0100_0193) ^ pc[63:32] ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
    endtask

    // Drive one cycle of stimulus just after the rising edge, then wait past the
    // falling edge so the monitors have sampled this cycle.
    task automatic step();
        bit          r;
        logic [63:0] tgt;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_req;
        if (!rst) begin
            mem_q.delete();
            exp_q.delete();
            exp_next        = 64'h0;
            imem_resp_valid = 1'b0;
            imem_req_ready  = 1'b0;
            redirect_valid  = 1'b0;
            stall_if        = 1'b0;
        end else begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = ins_of(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
            imem_req_ready = ($urandom_range(99) < p_ready);
            stall_if       = force_stall || ($urandom_range(99) < p_stall);
            r = 1'b0;
            if (force_redir) begin
                r = 1'b1; tgt = force_target; force_redir = 1'b0;
            end else if (redir_on_resp && imem_resp_valid) begin
                r = 1'b1; tgt = force_target; redir_on_resp = 1'b0; stall_if = 1'b1;
            end else if ($urandom_range(999) < p_redir) begin
                r = 1'b1; tgt = {$urandom, $urandom};
                if ($urandom_range(3) == 0) tgt[63:8] = '1;
            end
            redirect_valid = r;
            redirect_pc    = r ? tgt : {$urandom, $urandom};
            if (r) begin
                exp_q.delete();
                exp_next = {tgt[63:2], 2'b00};
            end
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: exp_next, ins: ins_of(exp_next)});
            exp_next = exp_next + 64'd4;
        end
        @(negedge clk);
        #1;
    endtask

    // Memory model: records accepted requests and checks the request address stream.
    always @(negedge clk) begin
        if (!rst) begin
            tb_req_pc = 64'h0;
        end else if (redirect_valid) begin
            chk("no_req_in_redirect_cycle", 64'(imem_req_valid), 64'd0);
            tb_req_pc = {redirect_pc[63:2], 2'b00};
        end else if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, tb_req_pc);
            tb_req_pc = tb_req_pc + 64'd4;
            mem_q.push_back('{addr: imem_req_addr,
                              due:  cyc + longint'($urandom_range(max_lat, min_lat))});
            chk("outstanding_le_depth", 64'(mem_q.size() <= 2), 64'd1);
        end
    end

    // Scoreboard monitor: the presented head must match the expected stream.
    always @(negedge clk) begin
        if (!rst) begin
            if (!rst_prev) begin
                chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
                chk("rst_if_valid", 64'(if_valid), 64'd0);
                chk("rst_if_pc", if_pc, 64'h0);
                chk("rst_if_instr", 64'(if_instruction), 64'(NOP_INSTR));
            end
        end else if (if_valid && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                fail_now("scoreboard_empty");
            end else begin
                chk("if_pc", if_pc, exp_q[0].pc);
                chk("if_instr", 64'(if_instruction), 64'(exp_q[0].ins));
                if (!stall_if) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end else if (!if_valid) begin
            chk("idle_if_pc", if_pc, 64'h0);
            chk("idle_if_instr", 64'(if_instruction), 64'(NOP_INSTR));
        end
        rst_prev = rst;
    end

    initial begin
        bit hit;
        rst_req = 1'b0;
        repeat (4) step();

        // Reset release with an always-ready, single-cycle memory.
        rst_req = 1'b1;
        step();
        chk("boot_no_req", 64'(imem_req_valid), 64'd0);
        step();
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", imem_req_addr, 64'h0);
        chk("first_if_valid_early", 64'(if_valid), 64'd0);
        step();
        chk("second_req_addr", imem_req_addr, 64'h4);
        chk("if_valid_before_latency", 64'(if_valid), 64'd0);
        step();
        chk("first_if_valid", 64'(if_valid), 64'd1);
        chk("first_if_pc", if_pc, 64'h0);
        repeat (10) step();

        // Stall long enough to fill the buffer; requests must stop.
        force_stall = 1'b1;
        repeat (5) step();
        chk("full_blocks_req", 64'(imem_req_valid), 64'd0);
        chk("full_if_valid", 64'(if_valid), 64'd1);
        force_stall = 1'b0;
        repeat (10) step();

        // Redirect with two requests outstanding.
        min_lat = 4; max_lat = 4;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            step();
            if (mem_q.size() == 2) hit = 1'b1;
        end
        if (!hit) fail_now("wait_two_outstanding");
        force_redir = 1'b1; force_target = 64'h100;
        step();
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            step();
            if (if_valid) hit = 1'b1;
        end
        if (!hit) fail_now("wait_after_redirect");
        else chk("redirect_first_pc", if_pc, 64'h100);
        repeat (10) step();

        // Redirect coincident with a response while stalled.
        min_lat = 2; max_lat = 2;
        redir_on_resp = 1'b1; force_target = 64'h2000;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            step();
            if (redirect_valid) hit = 1'b1;
        end
        if (!hit) begin
            fail_now("wait_resp_redirect");
        end else begin
            chk("coinc_stall", 64'(stall_if), 64'd1);
            chk("coinc_resp", 64'(imem_resp_valid), 64'd1);
            step();
            chk("coinc_fifo_empty", 64'(if_valid), 64'd0);
            chk("coinc_new_req_valid", 64'(imem_req_valid), 64'd1);
            chk("coinc_new_req_addr", imem_req_addr, 64'h2000);
        end
        repeat (10) step();

        // Misaligned redirect target once the memory has drained.
        min_lat = 1; max_lat = 1; p_ready = 0;
        repeat (8) step();
        p_ready = 100;
        force_redir = 1'b1; force_target = 64'h103;
        step();
        step();
        chk("align_req_valid", 64'(imem_req_valid), 64'd1);
        chk("align_req_addr", imem_req_addr, 64'h100);
        repeat (8) step();

        // Fetch across the top of the address space.
        force_redir = 1'b1; force_target = 64'hFFFF_FFFF_FFFF_FFF8;
        repeat (12) step();

        // Random traffic with a mid-run reset.
        p_ready = 70; min_lat = 1; max_lat = 4; p_stall = 25; p_redir = 15;
        popped = 0;
        for (int i = 0; i < 20000 && popped < 1000; i++) begin
            if (i == 500) rst_req = 1'b0;
            if (i == 503) rst_req = 1'b1;
            step();
        end
        if (popped < 1000) fail_now("random_phase_budget");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
